// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM stepping FETCH/DECODE/EXEC/MEM/WB; zero-wait latency 3 (branch) to 5 (load) cycles.
// imem_ready/dmem_ready low holds FETCH/MEM with the request asserted; illegal encodings park in TRAP until rst.
module multicycle_ctrl #(
  parameter bit SUPPORT_UPPER = 1'b1,
  parameter bit STRICT_DECODE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  state_t st;
  cls_t   cls;
  cls_t   dec_cls;
  logic   dec_ok;

  // Opcode classification plus optional funct3/funct7 validity screening.
  always_comb begin
    dec_cls = C_R;
    dec_ok  = 1'b0;
    case (opcode)
      OP_R: begin
        dec_cls = C_R;
        dec_ok  = !STRICT_DECODE || (funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OP_IALU: begin
        dec_cls = C_IALU;
        if (!STRICT_DECODE)        dec_ok = 1'b1;
        else if (funct3 == 3'b001) dec_ok = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) dec_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       dec_ok = 1'b1;
      end
      OP_LOAD: begin
        dec_cls = C_LOAD;
        dec_ok  = !STRICT_DECODE || (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111);
      end
      OP_STORE: begin
        dec_cls = C_STORE;
        dec_ok  = !STRICT_DECODE || (funct3 <= 3'b010);
      end
      OP_BRANCH: begin
        dec_cls = C_BRANCH;
        dec_ok  = !STRICT_DECODE || (funct3 != 3'b010 && funct3 != 3'b011);
      end
      OP_JAL: begin
        dec_cls = C_JAL;
        dec_ok  = 1'b1;
      end
      OP_JALR: begin
        dec_cls = C_JALR;
        dec_ok  = !STRICT_DECODE || (funct3 == 3'b000);
      end
      OP_LUI: begin
        dec_cls = C_LUI;
        dec_ok  = SUPPORT_UPPER;
      end
      OP_AUIPC: begin
        dec_cls = C_AUIPC;
        dec_ok  = SUPPORT_UPPER;
      end
      default: begin
        dec_cls = C_R;
        dec_ok  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= FETCH;
      cls     <= C_R;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      case (st)
        FETCH:  if (imem_ready) st <= DECODE;
        DECODE: begin
          cls <= dec_cls;
          st  <= dec_ok ? EXEC : TRAP;
        end
        EXEC: begin
          case (cls)
            C_BRANCH:        st <= FETCH;
            C_LOAD, C_STORE: st <= MEM;
            default:         st <= WB;
          endcase
        end
        MEM:     if (dmem_ready) st <= (cls == C_STORE) ? FETCH : WB;
        WB:      st <= FETCH;
        TRAP:    st <= TRAP;
        default: st <= FETCH;
      endcase
    end
  end

  // Moore decode of state/class; only ready-qualified pulses and branch pc_src look at inputs.
  always_comb begin
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (st)
      FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      EXEC: begin
        case (cls)
          C_R:                     alu_op = 2'b10;
          C_IALU: begin
            alu_op    = 2'b11;
            alu_src_b = 1'b1;
          end
          C_LOAD, C_STORE, C_JALR: alu_src_b = 1'b1;
          C_JAL, C_AUIPC: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
          end
          C_BRANCH: begin
            alu_op   = 2'b01;
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'b10 : 2'b00;
            retire   = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (cls == C_STORE && dmem_ready) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        case (cls)
          C_LOAD:         wb_sel = 2'b01;
          C_JAL, C_JALR:  wb_sel = 2'b10;
          C_LUI:          wb_sel = 2'b11;
          default:        wb_sel = 2'b00;
        endcase
        pc_src = (cls == C_JAL || cls == C_JALR) ? 2'b01 : 2'b00;
      end
      TRAP:    illegal = 1'b1;
      default: ;
    endcase
  end

  assign state = st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: default instance plus a SUPPORT_UPPER=0/STRICT_DECODE=0/CNT_W=4 instance,
// each compared cycle by cycle against an instruction-level expected trace.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0]  state;
    logic        imem_req, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a, alu_src_b;
    logic [1:0]  alu_op;
    logic        dmem_req, dmem_we, reg_write;
    logic [1:0]  wb_sel;
    logic        retire, illegal;
    logic [31:0] instret;
  } obs_t;

  typedef struct {
    obs_t e;
    bit   ir, dr, bt, opv;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, imem_ready, dmem_ready, branch_taken;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic       a_imem_req, a_ir_write, a_pc_write, a_alu_src_a, a_alu_src_b, a_dmem_req, a_dmem_we;
  logic       a_reg_write, a_retire, a_illegal;
  logic [1:0] a_pc_src, a_alu_op, a_wb_sel;
  logic [2:0] a_state;
  logic [31:0] a_instret;
  logic       b_imem_req, b_ir_write, b_pc_write, b_alu_src_a, b_alu_src_b, b_dmem_req, b_dmem_we;
  logic       b_reg_write, b_retire, b_illegal;
  logic [1:0] b_pc_src, b_alu_op, b_wb_sel;
  logic [2:0] b_state;
  logic [3:0] b_instret;

  multicycle_ctrl u_main (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(a_imem_req), .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_src(a_pc_src),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op), .dmem_req(a_dmem_req),
    .dmem_we(a_dmem_we), .reg_write(a_reg_write), .wb_sel(a_wb_sel), .retire(a_retire),
    .illegal(a_illegal), .instret(a_instret), .state(a_state)
  );

  multicycle_ctrl #(.SUPPORT_UPPER(1'b0), .STRICT_DECODE(1'b0), .CNT_W(4)) u_var (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(b_imem_req), .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op), .dmem_req(b_dmem_req),
    .dmem_we(b_dmem_we), .reg_write(b_reg_write), .wb_sel(b_wb_sel), .retire(b_retire),
    .illegal(b_illegal), .instret(b_instret), .state(b_state)
  );

  bit   sel;
  obs_t oa, ob, o;
  assign oa = {a_state, a_imem_req, a_ir_write, a_pc_write, a_pc_src, a_alu_src_a, a_alu_src_b,
               a_alu_op, a_dmem_req, a_dmem_we, a_reg_write, a_wb_sel, a_retire, a_illegal, a_instret};
  assign ob = {b_state, b_imem_req, b_ir_write, b_pc_write, b_pc_src, b_alu_src_a, b_alu_src_b,
               b_alu_op, b_dmem_req, b_dmem_we, b_reg_write, b_wb_sel, b_retire, b_illegal,
               28'd0, b_instret};
  assign o = sel ? ob : oa;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] exp_cnt = 32'd0;

  localparam logic [6:0] R = 7'h33, IA = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63;
  localparam logic [6:0] JAL = 7'h6f, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17;
  logic [6:0] ops [9] = '{R, IA, LD, ST, BR, JAL, JALR, LUI, AUIPC};

  function automatic logic [31:0] cmask();
    return sel ? 32'h0000_000F : 32'hFFFF_FFFF;
  endfunction

  // Instruction legality straight from the encoding rules of the ISA subset.
  function automatic bit legal_f(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    bit sup    = !sel;
    bit strict = !sel;
    case (opc)
      R:     return !strict || f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      IA:    return !strict || (f3 == 3'd1 ? f7 == 7'h00 :
                                f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1);
      LD:    return !strict || f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      ST:    return !strict || f3 <= 3'd2;
      BR:    return !strict || !(f3 inside {3'd2, 3'd3});
      JAL:   return 1'b1;
      JALR:  return !strict || f3 == 3'd0;
      LUI, AUIPC: return sup;
      default: return 1'b0;
    endcase
  endfunction

  function automatic step_t blank(input logic [2:0] st);
    step_t s;
    s.e         = '0;
    s.e.state   = st;
    s.e.instret = exp_cnt & cmask();
    s.ir        = 1'($urandom);
    s.dr        = 1'($urandom);
    s.bt        = 1'($urandom);
    s.opv       = 1'b1;
    return s;
  endfunction

  task automatic check_step(input step_t s, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [6:0] f7, input string tag);
    opcode       = s.opv ? opc : 7'($urandom);
    funct3       = s.opv ? f3  : 3'($urandom);
    funct7       = s.opv ? f7  : 7'($urandom);
    imem_ready   = s.ir;
    dmem_ready   = s.dr;
    branch_taken = s.bt;
    @(negedge clk);
    vectors++;
    assert (o === s.e) else begin
      miscompares++;
      $error("FAIL %s cyc%0d observed %h expected %h", tag, cyc, o, s.e);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step_t s;
    rst        = 1'b1;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exp_cnt = 32'd0;
    s = blank(3'd0);
    s.e.imem_req = 1'b1;
    s.ir = 1'b0;
    check_step(s, 7'd0, 3'd0, 7'd0, "reset");
  endtask

  // Builds the expected cycle trace of one instruction, then drives and checks it.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input int iw, input int dw, input bit bt, input bit abort, input string tag);
    step_t q[$];
    step_t s;
    bit    lg = legal_f(opc, f3, f7);
    for (int i = 0; i < iw; i++) begin
      s = blank(3'd0); s.e.imem_req = 1'b1; s.ir = 1'b0; s.opv = 1'b0; q.push_back(s);
    end
    s = blank(3'd0); s.e.imem_req = 1'b1; s.e.ir_write = 1'b1; s.ir = 1'b1; q.push_back(s);
    q.push_back(blank(3'd1));
    if (!lg) begin
      for (int i = 0; i < 3; i++) begin
        s = blank(3'd5); s.e.illegal = 1'b1; q.push_back(s);
      end
    end else begin
      s = blank(3'd2);
      case (opc)
        R:  s.e.alu_op = 2'b10;
        IA: begin s.e.alu_op = 2'b11; s.e.alu_src_b = 1'b1; end
        LD, ST, JALR: s.e.alu_src_b = 1'b1;
        JAL, AUIPC: begin s.e.alu_src_a = 1'b1; s.e.alu_src_b = 1'b1; end
        BR: begin
          s.e.alu_op = 2'b01; s.e.pc_write = 1'b1; s.e.retire = 1'b1;
          s.e.pc_src = bt ? 2'b10 : 2'b00; s.bt = bt;
        end
        default: ;
      endcase
      q.push_back(s);
      if (opc == BR) exp_cnt++;
      if (opc == LD || opc == ST) begin
        for (int i = 0; i < (abort ? 1 : dw); i++) begin
          s = blank(3'd3); s.e.dmem_req = 1'b1; s.e.dmem_we = (opc == ST); s.dr = 1'b0;
          q.push_back(s);
        end
        if (!abort) begin
          s = blank(3'd3); s.e.dmem_req = 1'b1; s.e.dmem_we = (opc == ST); s.dr = 1'b1;
          if (opc == ST) begin s.e.pc_write = 1'b1; s.e.retire = 1'b1; end
          q.push_back(s);
          if (opc == ST) exp_cnt++;
        end
      end
      if (!abort && opc != BR && opc != ST) begin
        s = blank(3'd4);
        s.e.reg_write = 1'b1; s.e.pc_write = 1'b1; s.e.retire = 1'b1;
        s.e.wb_sel = (opc == LD) ? 2'b01 : (opc == JAL || opc == JALR) ? 2'b10 :
                     (opc == LUI) ? 2'b11 : 2'b00;
        s.e.pc_src = (opc == JAL || opc == JALR) ? 2'b01 : 2'b00;
        q.push_back(s);
        exp_cnt++;
      end
    end
    foreach (q[i]) check_step(q[i], opc, f3, f7, tag);
    if (!lg || abort) do_reset();
  endtask

  task automatic rand_instrs(input int n);
    for (int i = 0; i < n; i++) begin
      int         k  = int'($urandom_range(0, 9));
      int         j  = int'($urandom_range(0, 3));
      logic [6:0] opc = (k == 9) ? 7'($urandom) : ops[k];
      logic [6:0] f7  = (j == 0) ? 7'h00 : (j == 1) ? 7'h20 : 7'($urandom);
      run_instr(opc, 3'($urandom), f7, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                1'($urandom), 1'b0, "rand");
    end
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; sel = 1'b0;
    @(posedge clk); #1;
    do_reset();
    run_instr(R,    3'd0, 7'h00, 0, 0, 1'b0, 1'b0, "r_add");
    run_instr(LD,   3'd2, 7'h00, 0, 2, 1'b0, 1'b0, "load_wait");
    run_instr(BR,   3'd0, 7'h00, 0, 0, 1'b1, 1'b0, "beq_taken");
    run_instr(BR,   3'd0, 7'h00, 0, 0, 1'b0, 1'b0, "beq_not");
    run_instr(JAL,  3'd0, 7'h00, 1, 0, 1'b0, 1'b0, "jal");
    run_instr(LUI,  3'd0, 7'h00, 0, 0, 1'b0, 1'b0, "lui");
    run_instr(AUIPC,3'd3, 7'h11, 2, 0, 1'b0, 1'b0, "auipc");
    run_instr(JALR, 3'd0, 7'h00, 0, 0, 1'b0, 1'b0, "jalr");
    run_instr(ST,   3'd1, 7'h00, 0, 1, 1'b0, 1'b0, "store");
    run_instr(IA,   3'd5, 7'h20, 0, 0, 1'b0, 1'b0, "srai");
    run_instr(JALR, 3'd1, 7'h00, 0, 0, 1'b0, 1'b0, "jalr_bad");
    run_instr(R,    3'd1, 7'h20, 0, 0, 1'b0, 1'b0, "r_strict_trap");
    run_instr(R,    3'd0, 7'h00, 0, 0, 1'b0, 1'b0, "r_after_trap");
    run_instr(LD,   3'd0, 7'h00, 0, 3, 1'b0, 1'b1, "load_rst_mid_mem");
    rand_instrs(60);

    sel = 1'b1;
    do_reset();
    run_instr(LUI,  3'd0, 7'h00, 0, 0, 1'b0, 1'b0, "lui_no_upper");
    run_instr(R,    3'd1, 7'h20, 0, 0, 1'b0, 1'b0, "r_loose");
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(IA, 3'd0, 7'h00, 0, 0, 1'b0, 1'b0, "wrap");
    run_instr(ST,   3'd2, 7'h00, 0, 2, 1'b0, 1'b1, "store_rst_mid_mem");
    rand_instrs(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
